bfly_r2_pipe: RTL and testbench
===============================

Name: bfly_r2_pipe

Overview:
- Parametrised, pipelined radix-2 DIT butterfly for the FFT datapath: out1 = y + w*x, out2 = y - w*x, on complex fixed-point operands.
- Next-generation replacement for the combinational butterfly.
- Adds a valid/ready handshake, a 4-stage pipeline with full-stall backpressure, rounding, per-transaction scale-by-half, per-transaction inverse (conjugate twiddle) mode, a sideband tag, and a sticky overflow flag.
- Sits between the stage memory read port and the write-back port of the FFT engine.

Parameters:
- DATA_W, 22, width of every data real/imag component, two's complement.
- FRAC_W, 11, data fraction bits; informational only, no arithmetic depends on it.
- W_W, 12, twiddle component width, two's complement.
- W_FRAC, 10, twiddle fraction bits; 1.0 = 1024 at the default.
- TAG_W, 6, width of the sideband tag carried alongside the data.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  block accepts the input this cycle
- x_real, x_img  in  DATA_W each  operand multiplied by the twiddle
- y_real, y_img  in  DATA_W each  pass-through operand
- w_real, w_img  in  W_W each  twiddle factor
- inv  in  1  1 = use conj(w), for IFFT
- scale  in  1  1 = divide both outputs by 2, rounded
- tag_in  in  TAG_W  sideband, returned unchanged with the result
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out1_real, out1_img, out2_real, out2_img  out  DATA_W each  results
- tag_out  out  TAG_W  tag of the current result
- ovf  out  1  sticky overflow flag
- ovf_clr  in  1  clears ovf

Behaviour:
- Reset: synchronous, active-low, clk is the only clock. While rst_n = 0 at a rising edge, all stage valid bits clear and ovf clears.
  - Outputs while in reset: out_valid = 0, all data outputs = 0, tag_out = 0, in_ready = 1.
  - Reset in the middle of operation discards every in-flight transaction; nothing is emitted afterwards.
- Handshake: an input transfers when in_valid & in_ready; an output transfers when out_valid & out_ready.
  - Output data and tag hold stable while out_valid & !out_ready.
- Pipeline advance: adv = out_ready | !out_valid.
  - in_ready = adv, combinational.
  - All four stages advance together on adv; bubbles are not compressed.
  - When adv = 0 every stage register holds.
- Latency: exactly 4 cycles from input transfer to out_valid, with no stalls. Throughput is 1 transaction per cycle.
- Stage 1: register all inputs. If inv, set wi = -w_img, else wi = w_img.
  - Negating the most negative twiddle value saturates to its positive maximum.
- Stage 2: form four full-width products (DATA_W+W_W bits): xr*wr, xi*wi, xr*wi, xi*wr.
- Stage 3: form G.
  - Gr = xr*wr - xi*wi; Gi = xr*wi + xi*wr, computed at DATA_W+W_W+1 bits.
  - Round half-up: add 2^(W_FRAC-1), then arithmetic shift right by W_FRAC.
  - Saturate the result to DATA_W+1 bits.
- Stage 4: compute y ± G at DATA_W+2 bits.
  - If scale: add 1, then arithmetic shift right by 1.
  - Reduce to DATA_W per the Optional Feature.
- Overflow: any of the four stage-4 results outside the DATA_W range sets ovf on the same edge the result is registered. The Stage 3 clamp also counts as an overflow.
  - Overflow during a stall is counted once per transaction, not once per held cycle.
- ovf_clr: clears ovf on the next edge. If a set and ovf_clr occur in the same cycle, the set wins.
- inv and scale are per-transaction and travel with their data; mixed settings back-to-back are legal.

Optional Feature:
- Macro: BFLY_SAT_EN.
- Defined: out-of-range results clamp to +(2^(DATA_W-1)-1) or -2^(DATA_W-1).
- Undefined: results wrap; the low DATA_W bits are kept.
- ovf reports the condition in both builds.

Test Plan:
- Identity twiddle (defaults): x=(2048,0), y=(4096,0), w=(1024,0), inv=0, scale=0 -> after 4 cycles out1=(6144,0), out2=(2048,0), tag_out = tag_in.
- -j twiddle: x=(2048,0), y=(4096,0), w=(0,-1024).
  - inv=0 -> out1=(4096,-2048), out2=(4096,2048).
  - inv=1 -> out1=(4096,2048), out2=(4096,-2048).
- Scale on the identity case with scale=1 -> out1=(3072,0), out2=(1024,0). Also y=(3,0), x=(0,0), scale=1 -> out1=(2,0), the round-half-up check.
- Overflow: y=(2000000,0), x=(200000,0), w=(1024,0).
  - With BFLY_SAT_EN: out1_real=2097151.
  - Without: out1_real=-1994304.
  - Both builds: ovf=1 and stays set; ovf_clr pulse -> ovf=0 next cycle.
- Backpressure: 8 back-to-back inputs with tags 0..7 while out_ready is low for cycles 5..8 -> in_ready low in those cycles, no loss or duplication, tags emerge 0..7 in order, data is bit-exact against a reference model.
- Reset mid-stream: drop rst_n for 1 cycle with 3 transactions in flight -> out_valid=0 and ovf=0 next cycle, no stale results emitted; a new input gives its result 4 cycles after acceptance.

Source files
------------

// File: rtl/bfly_r2_pipe.sv
// bfly_r2_pipe: pipelined radix-2 DIT butterfly, out1 = y + w*x, out2 = y - w*x.
// Four register stages share one advance enable. A downstream stall freezes the
// whole pipe. Rounding is half-up. The inverse (conjugate twiddle) and
// scale-by-half settings travel with each transaction.
// Build option: define BFLY_SAT_EN to clamp out-of-range results. Without it,
// results wrap to the low DATA_W bits. ovf reports the condition in both builds.

// One output lane of the last stage: y +/- G at DATA_W+2 bits, optional halving,
// then reduction to DATA_W bits with an out-of-range flag.
module bfly_r2_out #(
  parameter int DATA_W = 22,
  parameter bit SUB    = 1'b0
) (
  input  logic signed [DATA_W-1:0] y,
  input  logic signed [DATA_W:0]   g,
  input  logic                     scale,
  output logic        [DATA_W-1:0] res,
  output logic                     ovf
);
  localparam int SW = DATA_W + 2;
  localparam logic signed [SW-1:0] R_MAX = SW'((64'sd1 <<< (DATA_W-1)) - 64'sd1);
  localparam logic signed [SW-1:0] R_MIN = -R_MAX - SW'(1);

  logic signed [SW-1:0] sum, red;

  // sum/difference, rounded halving, range check and reduction
  always_comb begin
    sum = SUB ? (SW'(y) - SW'(g)) : (SW'(y) + SW'(g));
    red = scale ? ((sum + SW'(1)) >>> 1) : sum;
    ovf = (red > R_MAX) || (red < R_MIN);
`ifdef BFLY_SAT_EN
    if (red > R_MAX)      res = R_MAX[DATA_W-1:0];
    else if (red < R_MIN) res = R_MIN[DATA_W-1:0];
    else                  res = red[DATA_W-1:0];
`else
    res = red[DATA_W-1:0];
`endif
  end
endmodule

module bfly_r2_pipe #(
  parameter int DATA_W = 22,
  parameter int FRAC_W = 11,
  parameter int W_W    = 12,
  parameter int W_FRAC = 10,
  parameter int TAG_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x_real,
  input  logic [DATA_W-1:0] x_img,
  input  logic [DATA_W-1:0] y_real,
  input  logic [DATA_W-1:0] y_img,
  input  logic [W_W-1:0]    w_real,
  input  logic [W_W-1:0]    w_img,
  input  logic              inv,
  input  logic              scale,
  input  logic [TAG_W-1:0]  tag_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out1_real,
  output logic [DATA_W-1:0] out1_img,
  output logic [DATA_W-1:0] out2_real,
  output logic [DATA_W-1:0] out2_img,
  output logic [TAG_W-1:0]  tag_out,
  output logic              ovf,
  input  logic              ovf_clr
);
  localparam int STAGES = 4;
  localparam int LANES  = 4;
  localparam int PW     = DATA_W + W_W;
  localparam int GW     = DATA_W + 1;
  localparam logic signed [W_W-1:0] W_MAX = {1'b0, {(W_W-1){1'b1}}};
  localparam logic signed [W_W-1:0] W_MIN = {1'b1, {(W_W-1){1'b0}}};
  localparam logic signed [PW:0] G_MAX = (PW+1)'((64'sd1 <<< (GW-1)) - 64'sd1);
  localparam logic signed [PW:0] G_MIN = -G_MAX - (PW+1)'(1);
  localparam logic signed [PW:0] G_RND = (PW+1)'(64'sd1 <<< (W_FRAC-1));

  // FRAC_W carries no arithmetic; only sanity-check it against the data width.
  if (FRAC_W < 0 || FRAC_W >= DATA_W) begin : g_bad_frac
    $error("FRAC_W must lie in [0, DATA_W)");
  end

  logic              adv;
  logic [STAGES:1]   vld_pipe;

  assign out_valid = vld_pipe[STAGES];
  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;

  // stage 1 registers
  logic signed [DATA_W-1:0] s1_xr, s1_xi, s1_yr, s1_yi;
  logic signed [W_W-1:0]    s1_wr, s1_wi;
  logic                     s1_scale;
  logic [TAG_W-1:0]         s1_tag;
  // stage 2 registers
  logic signed [PW-1:0]     s2_prr, s2_pii, s2_pri, s2_pir;
  logic signed [DATA_W-1:0] s2_yr, s2_yi;
  logic                     s2_scale;
  logic [TAG_W-1:0]         s2_tag;
  // stage 3 registers
  logic signed [GW-1:0]     s3_gr, s3_gi;
  logic                     s3_gofl;
  logic signed [DATA_W-1:0] s3_yr, s3_yi;
  logic                     s3_scale;
  logic [TAG_W-1:0]         s3_tag;
  // stage 4 (output) registers
  logic [LANES-1:0][DATA_W-1:0] res_q;
  logic [TAG_W-1:0]             tag_q;

  // Conjugate twiddle for inverse mode; -MIN has no encoding, so it clamps to MAX.
  logic signed [W_W-1:0] wi_in;
  always_comb begin
    wi_in = $signed(w_img);
    if (inv) wi_in = (w_img == W_MIN) ? W_MAX : -$signed(w_img);
  end

  // Clamp a rounded product sum into GW bits; the top bit flags a clamp.
  function automatic logic [GW:0] clamp_g(input logic signed [PW:0] v);
    if (v > G_MAX) return {1'b1, G_MAX[GW-1:0]};
    if (v < G_MIN) return {1'b1, G_MIN[GW-1:0]};
    return {1'b0, v[GW-1:0]};
  endfunction

  logic signed [PW:0]   gr_full, gi_full, gr_sh, gi_sh;
  logic        [GW-1:0] gr_sat, gi_sat;
  logic                 gr_of, gi_of;

  // complex product recombination, round half-up, clamp
  always_comb begin
    gr_full = (PW+1)'(s2_prr) - (PW+1)'(s2_pii);
    gi_full = (PW+1)'(s2_pri) + (PW+1)'(s2_pir);
    gr_sh   = (gr_full + G_RND) >>> W_FRAC;
    gi_sh   = (gi_full + G_RND) >>> W_FRAC;
    {gr_of, gr_sat} = clamp_g(gr_sh);
    {gi_of, gi_sat} = clamp_g(gi_sh);
  end

  // Output lanes: 0 = out1 re, 1 = out1 im, 2 = out2 re, 3 = out2 im.
  logic [LANES-1:0][DATA_W-1:0] lane_y, lane_res;
  logic [LANES-1:0][DATA_W:0]   lane_g;
  logic [LANES-1:0]             lane_ovf;

  assign lane_y = {s3_yi, s3_yr, s3_yi, s3_yr};
  assign lane_g = {s3_gi, s3_gr, s3_gi, s3_gr};

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    bfly_r2_out #(.DATA_W(DATA_W), .SUB(l >= 2)) u_out (
      .y     (lane_y[l]),
      .g     (lane_g[l]),
      .scale (s3_scale),
      .res   (lane_res[l]),
      .ovf   (lane_ovf[l])
    );
  end

  // valid shift register; the whole pipe moves only on adv
  always_ff @(posedge clk) begin
    if (!rst_n)   vld_pipe <= '0;
    else if (adv) vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
  end

  // stage 1: capture operands and the (possibly conjugated) twiddle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {s1_xr, s1_xi, s1_yr, s1_yi} <= '0;
      {s1_wr, s1_wi, s1_scale, s1_tag} <= '0;
    end else if (adv) begin
      s1_xr <= x_real; s1_xi <= x_img;
      s1_yr <= y_real; s1_yi <= y_img;
      s1_wr <= w_real; s1_wi <= wi_in;
      s1_scale <= scale; s1_tag <= tag_in;
    end
  end

  // stage 2: four full-width partial products
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {s2_prr, s2_pii, s2_pri, s2_pir} <= '0;
      {s2_yr, s2_yi, s2_scale, s2_tag} <= '0;
    end else if (adv) begin
      s2_prr <= PW'(s1_xr) * PW'(s1_wr);
      s2_pii <= PW'(s1_xi) * PW'(s1_wi);
      s2_pri <= PW'(s1_xr) * PW'(s1_wi);
      s2_pir <= PW'(s1_xi) * PW'(s1_wr);
      s2_yr <= s1_yr; s2_yi <= s1_yi;
      s2_scale <= s1_scale; s2_tag <= s1_tag;
    end
  end

  // stage 3: rounded, clamped G = w*x
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {s3_gr, s3_gi, s3_gofl} <= '0;
      {s3_yr, s3_yi, s3_scale, s3_tag} <= '0;
    end else if (adv) begin
      s3_gr <= gr_sat; s3_gi <= gi_sat;
      s3_gofl <= gr_of | gi_of;
      s3_yr <= s2_yr; s3_yi <= s2_yi;
      s3_scale <= s2_scale; s3_tag <= s2_tag;
    end
  end

  // stage 4: registered results, held stable while stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q <= '0;
      tag_q <= '0;
    end else if (adv) begin
      res_q <= lane_res;
      tag_q <= s3_tag;
    end
  end

  // Sticky overflow. Setting only on adv counts a stalled transaction once;
  // a set in the same cycle as ovf_clr wins.
  always_ff @(posedge clk) begin
    if (!rst_n)                                           ovf <= 1'b0;
    else if (adv && vld_pipe[3] && (s3_gofl || |lane_ovf)) ovf <= 1'b1;
    else if (ovf_clr)                                     ovf <= 1'b0;
  end

  assign out1_real = res_q[0];
  assign out1_img  = res_q[1];
  assign out2_real = res_q[2];
  assign out2_img  = res_q[3];
  assign tag_out   = tag_q;
endmodule

// File: tb/tb_bfly_r2_pipe.sv
// Bench for bfly_r2_pipe: directed test-plan steps plus randomized traffic,
// all results checked against an integer reference model of the butterfly.
module tb_bfly_r2_pipe;
  localparam int DW = 22;
  localparam int WW = 12;
  localparam int TW = 6;
  localparam longint DMAX = 2097151, DMIN = -2097152;
  localparam longint GMAX = 4194303, GMIN = -4194304;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          in_valid = 1'b0, in_ready;
  logic [DW-1:0] x_real = '0, x_img = '0, y_real = '0, y_img = '0;
  logic [WW-1:0] w_real = '0, w_img = '0;
  logic          inv = 1'b0, scale = 1'b0;
  logic [TW-1:0] tag_in = '0;
  logic          out_valid, out_ready = 1'b1;
  logic [DW-1:0] out1_real, out1_img, out2_real, out2_img;
  logic [TW-1:0] tag_out;
  logic          ovf, ovf_clr = 1'b0;

  bfly_r2_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_real(x_real), .x_img(x_img), .y_real(y_real), .y_img(y_img),
    .w_real(w_real), .w_img(w_img), .inv(inv), .scale(scale), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out1_real(out1_real), .out1_img(out1_img), .out2_real(out2_real), .out2_img(out2_img),
    .tag_out(tag_out), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0, n_out = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string nm, input longint a, b, c, d);
    chk({nm, "_out1_real"}, $signed(out1_real), a);
    chk({nm, "_out1_img"},  $signed(out1_img),  b);
    chk({nm, "_out2_real"}, $signed(out2_real), c);
    chk({nm, "_out2_img"},  $signed(out2_img),  d);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    longint o1r, o1i, o2r, o2i;
    int     tag;
    bit     ovf;
  } exp_t;

  function automatic longint fin(input longint y, g, input bit sub, sc, output bit of);
    longint s;
    s  = sub ? y - g : y + g;
    if (sc) s = (s + 1) >>> 1;
    of = (s > DMAX) || (s < DMIN);
    if (of) begin
`ifdef BFLY_SAT_EN
      s = (s > 0) ? DMAX : DMIN;
`else
      s = ((s + 2097152) & 64'sh3FFFFF) - 2097152;
`endif
    end
    return s;
  endfunction

  function automatic exp_t model(input longint xr, xi, yr, yi, wr, wi, input bit iv, sc, input int tg);
    exp_t e;
    longint w2, gr, gi;
    bit f;
    w2 = iv ? -wi : wi;
    if (w2 > 2047) w2 = 2047;
    gr = ((xr * wr - xi * w2) + 512) >>> 10;
    gi = ((xr * w2 + xi * wr) + 512) >>> 10;
    e.ovf = 1'b0;
    if (gr > GMAX) begin gr = GMAX; e.ovf = 1'b1; end
    if (gr < GMIN) begin gr = GMIN; e.ovf = 1'b1; end
    if (gi > GMAX) begin gi = GMAX; e.ovf = 1'b1; end
    if (gi < GMIN) begin gi = GMIN; e.ovf = 1'b1; end
    e.o1r = fin(yr, gr, 1'b0, sc, f); e.ovf |= f;
    e.o1i = fin(yi, gi, 1'b0, sc, f); e.ovf |= f;
    e.o2r = fin(yr, gr, 1'b1, sc, f); e.ovf |= f;
    e.o2i = fin(yi, gi, 1'b1, sc, f); e.ovf |= f;
    e.tag = tg;
    return e;
  endfunction

  // ---------------- scoreboard monitor ----------------
  exp_t   q[$];
  bit     stall_prev = 1'b0;
  longint hold_d;
  int     hold_t;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_out1_real", $signed(out1_real), hold_d);
        chk("hold_tag", tag_out, hold_t);
      end
      stall_prev = out_valid && !out_ready;
      hold_d = $signed(out1_real);
      hold_t = tag_out;
      if (out_valid && q.size() == 0) chk("spurious_out_valid", out_valid, 0);
      else if (out_valid && out_ready) begin
        chk("sb_out1_real", $signed(out1_real), q[0].o1r);
        chk("sb_out1_img",  $signed(out1_img),  q[0].o1i);
        chk("sb_out2_real", $signed(out2_real), q[0].o2r);
        chk("sb_out2_img",  $signed(out2_img),  q[0].o2i);
        chk("sb_tag", tag_out, q[0].tag);
        if (q[0].ovf) chk("sb_ovf", ovf, 1);
        void'(q.pop_front());
        n_out++;
      end
      if (in_valid && in_ready)
        q.push_back(model($signed(x_real), $signed(x_img), $signed(y_real), $signed(y_img),
                          $signed(w_real), $signed(w_img), inv, scale, tag_in));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input longint xr, xi, yr, yi, wr, wi, input bit iv, sc, input int tg);
    x_real = DW'(xr); x_img = DW'(xi); y_real = DW'(yr); y_img = DW'(yi);
    w_real = WW'(wr); w_img = WW'(wi); inv = iv; scale = sc; tag_in = TW'(tg);
  endtask

  task automatic rand_data(input int tg);
    drive($urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
          1'($urandom), 1'($urandom), tg);
  endtask

  // One isolated transaction into an empty pipe; returns at the negedge where
  // out_valid first shows, after checking acceptance, latency and tag.
  task automatic do1(input string nm, input longint xr, xi, yr, yi, wr, wi,
                     input bit iv, sc, input int tg);
    int n;
    @(posedge clk); #1;
    drive(xr, xi, yr, yi, wr, wi, iv, sc, tg);
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk({nm, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 10);
    chk({nm, "_latency"}, n, 4);
    chk({nm, "_tag"}, tag_out, tg);
  endtask

  initial begin
    int idx, sent, base;
    bit acc;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_ovf", ovf, 0);
    chk("rst_tag", tag_out, 0);
    chk4("rst", 0, 0, 0, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // identity, -j twiddle both directions, scaling and round half-up
    do1("ident", 2048, 0, 4096, 0, 1024, 0, 0, 0, 5);
    chk4("ident", 6144, 0, 2048, 0);
    do1("mj_fwd", 2048, 0, 4096, 0, 0, -1024, 0, 0, 6);
    chk4("mj_fwd", 4096, -2048, 4096, 2048);
    do1("mj_inv", 2048, 0, 4096, 0, 0, -1024, 1, 0, 7);
    chk4("mj_inv", 4096, 2048, 4096, -2048);
    do1("scale", 2048, 0, 4096, 0, 1024, 0, 0, 1, 8);
    chk4("scale", 3072, 0, 1024, 0);
    do1("rnd_half", 0, 0, 3, 0, 1024, 0, 0, 1, 9);
    chk4("rnd_half", 2, 0, 2, 0);
    // conjugating the most negative twiddle clamps to +2047
    do1("wneg_sat", 0, 1024, 0, 0, 0, -2048, 1, 0, 10);
    chk4("wneg_sat", -2047, 0, 2047, 0);
    chk("no_ovf_yet", ovf, 0);

    // data-path overflow, stickiness and clear
    do1("ovf", 200000, 0, 2000000, 0, 1024, 0, 0, 0, 11);
`ifdef BFLY_SAT_EN
    chk4("ovf", 2097151, 0, 1800000, 0);
`else
    chk4("ovf", -1994304, 0, 1800000, 0);
`endif
    chk("ovf_set", ovf, 1);
    repeat (3) begin @(negedge clk); chk("ovf_sticky", ovf, 1); end
    @(posedge clk); #1 ovf_clr = 1'b1;
    @(posedge clk); #1 ovf_clr = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", ovf, 0);

    // G clamp inside the multiplier stage also flags overflow
    do1("gclamp", -2097152, -2097152, 0, 0, -2048, -2048, 0, 1, 12);
`ifdef BFLY_SAT_EN
    chk4("gclamp", 0, 2097151, 0, -2097151);
`else
    chk4("gclamp", 0, -2097152, 0, -2097151);
`endif
    chk("gclamp_ovf", ovf, 1);
    @(posedge clk); #1 ovf_clr = 1'b1;
    @(posedge clk); #1 ovf_clr = 1'b0;

    // backpressure: 8 back-to-back inputs, out_ready low in cycles 5..8
    base = n_out; idx = 0; acc = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      @(posedge clk); #1;
      out_ready = !(c >= 5 && c <= 8);
      if (idx == 8) in_valid = 1'b0;
      else if (!in_valid || acc) begin rand_data(idx); in_valid = 1'b1; end
      @(negedge clk);
      chk($sformatf("bp_in_ready_c%0d", c), in_ready, (c >= 5 && c <= 8) ? 0 : 1);
      acc = in_valid && in_ready;
      if (acc) idx++;
    end
    chk("bp_out_count", n_out - base, 8);

    // randomized traffic with random backpressure
    sent = 0; acc = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < 1500 && sent < 300; c++) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || acc) begin
        rand_data($urandom_range(0, 63));
        in_valid = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) sent++;
    end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20 && q.size() != 0; c++) @(negedge clk);
    chk("rand_sent", sent, 300);
    chk("rand_drained", q.size(), 0);

    // reset with 3 transactions in flight
    do1("pre_rst", 200000, 0, 2000000, 0, 1024, 0, 0, 0, 20);
    chk("pre_rst_ovf", ovf, 1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      rand_data(21 + k); in_valid = 1'b1;
    end
    @(posedge clk); #1 in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_ovf", ovf, 0);
    repeat (6) begin @(negedge clk); chk("post_rst_idle", out_valid, 0); end
    do1("after_rst", 2048, 0, 4096, 0, 1024, 0, 0, 0, 30);
    chk4("after_rst", 6144, 0, 2048, 0);
    repeat (3) @(negedge clk);
    chk("final_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
